// File: rtl/ddr_pkg.sv
// Shared DDR controller package: default bus geometry and timing constants
// used by the command FSM, the write-side bus-enable logic and the read
// capture path, plus the helper that sizes the read capture window.
package ddr_pkg;

  localparam int DDR_DATA_W = 16;  // DQ width
  localparam int DDR_CL     = 2;   // CAS latency in clk cycles
  localparam int DDR_BL     = 4;   // burst length in beats (two beats per clk)

  // Window tracker width: slots for the CAS latency plus the burst duration.
  function automatic int rd_win_width(input int cl, input int bl);
    return cl + bl / 2;
  endfunction

  localparam int DDR_RD_WIN_W = rd_win_width(DDR_CL, DDR_BL);

endpackage

// File: rtl/ddr_rd_fifo.sv
// Small synchronous FIFO for captured read words. The head entry is read
// straight from the storage registers, so dout never depends combinationally
// on din. A push into a full FIFO is accepted when a pop happens in the same
// cycle. DEPTH must be a power of two, at least 2.
module ddr_rd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (ADDR_W + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write; entries are cleared on reset so the head reads zero.
  // NOTE: this memory is reset only because it is tiny and the head must read
  // zero out of reset; larger RAMs should stay unreset so they map to RAM cells.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddr_rd_capture.sv
// DDR read capture path. A READ command opens a capture window CL cycles
// later lasting BL/2 clk cycles; each window cycle packs {dq_fall, dq_rise}
// into one word and pushes it into a small FIFO drained by valid/ready.
// Optional feature macro: DDR_RD_PREAMBLE_CHK_EN enables the DQS preamble
// check that drives the sticky preamble_err flag.
module ddr_rd_capture
  import ddr_pkg::*;
#(
  parameter int DATA_W     = DDR_DATA_W,
  parameter int CL         = DDR_CL,
  parameter int BL         = DDR_BL,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_issue,
  input  logic [DATA_W-1:0]   dq_rise,
  input  logic [DATA_W-1:0]   dq_fall,
  input  logic                dqs_pre,
  output logic [2*DATA_W-1:0] rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                rd_busy,
  output logic                rd_ovf,
  output logic                preamble_err
);

  localparam int WIN_W = rd_win_width(CL, BL);
  // Slots CL-1 .. CL+BL/2-2 reach bit 0 exactly in the burst's capture cycles.
  localparam logic [WIN_W-1:0] ISSUE_MASK =
    ((WIN_W'(1) << (BL / 2)) - WIN_W'(1)) << (CL - 1);

  logic [WIN_W-1:0] win;
  logic [WIN_W-1:0] win_next;
  logic             capture;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  // Age every pending slot by one cycle, then merge a new read's slots.
  always_comb begin
    // NOTE: assigning the default first covers every path, so no latch forms.
    win_next = win >> 1;
    if (rd_issue) win_next = win_next | ISSUE_MASK;
  end

  // Window tracker register; reset aborts any pending or active window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) win <= '0;
    else      win <= win_next;
  end

  assign capture  = win[0];
  assign rd_busy  = |win;
  assign rd_valid = !fifo_empty;
  assign pop      = rd_valid && rd_ready;

  ddr_rd_fifo #(
    .WIDTH(2 * DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (capture),
    .din  ({dq_fall, dq_rise}),
    .pop  (pop),
    .full (fifo_full),
    .empty(fifo_empty),
    .dout (rd_data)
  );

  // Sticky overflow: a captured word found the FIFO full with nothing leaving.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               rd_ovf <= 1'b0;
    else if (capture && fifo_full && !pop)  rd_ovf <= 1'b1;
  end

`ifdef DDR_RD_PREAMBLE_CHK_EN
  logic capture_q;
  logic perr_q;

  // Remember last cycle's capture flag to find the first cycle of a window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) capture_q <= 1'b0;
    else      capture_q <= capture;
  end

  // Sticky preamble error: DQS must still be low just before the first beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 perr_q <= 1'b0;
    else if (capture && !capture_q && dqs_pre) perr_q <= 1'b1;
  end

  assign preamble_err = perr_q;
`else
  logic unused_dqs_pre;

  assign unused_dqs_pre = dqs_pre;
  assign preamble_err   = 1'b0;
`endif

endmodule

// File: doc/ddr_rd_capture.md
# ddr_rd_capture

Read-side data path for the DDR controller; counterpart of the write-side bus-enable logic. When a READ command is issued on the DDR bus, the block opens a capture window CL cycles later, holds it for BL/2 clk cycles, and packs each cycle's rising/falling DQ samples into one system word. Captured words go into a small FIFO that the system side drains with a valid/ready handshake. It sits between the DQ/DQS input registers and the system read port.

## Interface
Parameters:
- DATA_W, 16, DDR DQ width
- CL, 2, CAS latency in clk cycles, 1..7
- BL, 4, burst length in beats (even, 2..8); each burst lasts BL/2 clk cycles
- FIFO_DEPTH, 4, read FIFO entries (power of two)

Ports:
- clk  in  1  controller clock
- rst  in  1  asynchronous, active-low reset
- rd_issue  in  1  one-cycle pulse in the cycle the READ command is driven on the bus
- dq_rise  in  DATA_W  DQ sampled on DQS rising edge, already retimed to clk
- dq_fall  in  DATA_W  DQ sampled on DQS falling edge, already retimed to clk
- dqs_pre  in  1  DQS level sampled one cycle before each capture cycle; used only with the macro
- rd_data  out  2*DATA_W  {dq_fall, dq_rise} at the FIFO head
- rd_valid  out  1  FIFO not empty
- rd_ready  in  1  system accepts rd_data when rd_valid && rd_ready
- rd_busy  out  1  capture window pending or active
- rd_ovf  out  1  sticky: a captured word was dropped because the FIFO was full
- preamble_err  out  1  sticky preamble error; tied to 0 without the macro

## Operation
- Window tracker: a shift register win[CL+BL/2-1:0] shifts toward bit 0 every clk. On rd_issue, bits CL-1 .. CL+BL/2-2 of the post-shift value are ORed to 1. A capture happens in any cycle where win[0]=1.
- Overlapping or back-to-back reads are supported. The OR merges windows, and each cycle captures at most one word.
- Capture: push {dq_fall, dq_rise} into the FIFO.
- FIFO full and no pop in the same cycle: drop the word and set rd_ovf.
- FIFO full with a pop in the same cycle: the push is accepted.
- Pop: rd_valid && rd_ready. rd_data is the registered head, so there is no combinational path from dq_* to rd_data.
- rd_busy = |win.
- rd_ovf and preamble_err clear only on reset.

## Timing
- rd_issue in cycle T: capture cycles are T+CL .. T+CL+BL/2-1.
- A word captured in cycle C is visible on rd_data with rd_valid=1 from C+1.
- Burst of BL=4 with CL=2 from T=0: captures at cycles 2 and 3, rd_valid rises at cycle 3.
- Reset values: win=0, FIFO empty, rd_valid=0, rd_data=0, rd_busy=0, rd_ovf=0, preamble_err=0.
- Reset asserted mid-burst aborts the window immediately. Data in flight is discarded, and no capture occurs until the next rd_issue after reset release.
- rd_issue is ignored while rst=0.

## Configuration
- DDR_RD_PREAMBLE_CHK_EN, defined:
  - In the first cycle of each window (win[0]=1 and the previous cycle had win[0]=0), dqs_pre must be 0.
  - If dqs_pre=1 in that cycle, preamble_err is set (sticky) from the next cycle.
  - Capture proceeds regardless.
- Undefined: dqs_pre is ignored, preamble_err is constant 0, and the check logic is absent.

## Structure
- Shared package ddr_pkg holds:
  - default DATA_W, CL and BL constants, shared with the command FSM and the write-side block;
  - a localparam helper for the window width CL+BL/2.
- Sub-module ddr_rd_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/dout, and push-when-full-with-pop allowed.
- The window tracker and the preamble check stay in the top level.

## Test plan
- Single read, CL=2, BL=4, rd_ready=1, rd_issue at T=0, dq pairs (A1,A0) at cycle 2 and (A3,A2) at cycle 3 -> rd_data={A1,A0} at cycle 3 and {A3,A2} at cycle 4; rd_busy high cycles 1..3.
- Back-to-back reads at T=0 and T=2, BL=4 -> 4 consecutive captures at cycles 2..5 with no gap or duplicate; rd_busy deasserts after the final capture.
- rd_ready=0, FIFO_DEPTH=4, three bursts (6 captures) -> first 4 words retained in order, rd_ovf=1 from the cycle after the 5th capture; drain -> words 1..4 exactly.
- Full FIFO with rd_ready=1 during a capture -> pop and push in the same cycle, no overflow, order preserved.
- Reset pulse at cycle 3 of a burst -> all outputs return to reset values asynchronously; no capture at cycle 4; a new read after release behaves as in the single-read scenario.
- With DDR_RD_PREAMBLE_CHK_EN: dqs_pre=1 in the first window cycle -> preamble_err=1 next cycle and stays set. Without the macro, the same stimulus -> preamble_err=0.
